axi_read_arb: RTL and testbench

AXI_READ_ARB -- requirements
Module: axi_read_arb

---
 rtl/cpu_defs.sv | 43 ++++
 rtl/axi_read_arb.sv | 180 ++++++++++++++++++
 tb/tb_axi_read_arb.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
//------------------------------------------------------------------------------
// Module  : cpu_defs (package)
// Purpose : Shared definitions for the CPU memory-side blocks: read-arbiter
//           FSM state encoding, AXI read owner encoding, default refill burst
//           length and the two-master round-robin grant helper.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_defs;

  // Read-arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // Owner encoding: 1 = instruction side, 0 = data side
  localparam logic OWNER_INST = 1'b1;
  localparam logic OWNER_DATA = 1'b0;

  // Beats in one cached line refill
  localparam int BEATS_DEFAULT = 16;

  // Two-master round-robin grant. On a tie the master that was not granted
  // last wins; a lone requester always wins. The result is only meaningful
  // when at least one request is pending.
  function automatic logic rr_grant(input logic inst_req,
                                    input logic data_req,
                                    input logic last_owner);
    if (inst_req && data_req) begin
      return ~last_owner;
    end else if (inst_req) begin
      return OWNER_INST;
    end else begin
      return OWNER_DATA;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_read_arb.sv
//------------------------------------------------------------------------------
// Module  : axi_read_arb
// Purpose : Arbitrates icache/dcache read requests onto one AXI read channel
//           (IDLE -> ADDR -> DATA), round-robin on ties, counts R beats and
//           flags burst-length protocol errors.
// Ports   : clk, rst                     - clock, synchronous active-high reset
//           inst_req/addr/cached         - icache request
//           data_req/addr/cached         - dcache request
//           inst_done, data_done         - pulse on the owner's last beat
//           beat_idx                     - current R beat (refill word index)
//           inst_ren, cache_ena          - latched owner / burst enable
//           inst/data_arvalid, _araddr   - per-master AR requests
//           inst/data_arready, _rvalid,
//           _rlast                       - per-master responses
//           err                          - sticky protocol error
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_read_arb
  import cpu_defs::*;
#(
  parameter int BEATS = BEATS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cached,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_cached,
  output logic        inst_done,
  output logic        data_done,
  output logic [3:0]  beat_idx,
  output logic        inst_ren,
  output logic        cache_ena,
  output logic        inst_arvalid,
  output logic        data_arvalid,
  output logic [31:0] inst_araddr,
  output logic [31:0] data_araddr,
  input  logic        inst_arready,
  input  logic        data_arready,
  input  logic        inst_rvalid,
  input  logic        inst_rlast,
  input  logic        data_rvalid,
  input  logic        data_rlast,
  output logic        err
);

  // Counter wide enough to hold BEATS+2 without wrapping, so an overlong
  // burst is still seen as overlong.
  localparam int CW = $clog2(BEATS + 3);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic          r_owner;
  logic          r_last_owner;
  logic          r_cached;
  logic [31:0]   r_addr;
  logic [3:0]    r_beat_idx;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic          w_any_req;
  logic          w_grant;
  logic          w_own_arready;
  logic          w_own_rvalid;
  logic          w_own_rlast;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_expect;

  assign w_any_req     = inst_req | data_req;
  assign w_grant       = rr_grant(inst_req, data_req, r_last_owner);
  // Only the owner's handshakes matter; the other master is ignored.
  assign w_own_arready = r_owner ? inst_arready : data_arready;
  assign w_own_rvalid  = r_owner ? inst_rvalid  : data_rvalid;
  assign w_own_rlast   = r_owner ? inst_rlast   : data_rlast;
  assign w_cnt_next    = r_cnt + CW'(1);
  assign w_expect      = r_cached ? CW'(BEATS) : CW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next       = r_state;
    inst_arvalid = 1'b0;
    data_arvalid = 1'b0;
    inst_done    = 1'b0;
    data_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        inst_arvalid = r_owner;
        data_arvalid = ~r_owner;
        if (w_own_arready) begin
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_own_rvalid && w_own_rlast) begin
          // A reset in this cycle aborts the transfer, so no completion.
          inst_done = r_owner & ~rst;
          data_done = ~r_owner & ~rst;
          w_next    = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Grant latching, beat counting and error tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWNER_DATA;
      r_last_owner <= OWNER_INST;
      r_cached     <= 1'b0;
      r_addr       <= 32'h0;
      r_beat_idx   <= 4'h0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_grant;
            r_last_owner <= w_grant;
            r_addr       <= w_grant ? inst_addr : data_addr;
            r_cached     <= w_grant ? inst_cached : data_cached;
          end
        end
        ST_ADDR: begin
          if (w_own_arready) begin
            r_beat_idx <= 4'h0;
            r_cnt      <= '0;
          end
        end
        ST_DATA: begin
          if (w_own_rvalid) begin
            r_beat_idx <= r_beat_idx + 4'h1;
            if (r_cnt <= CW'(BEATS)) begin
              r_cnt <= w_cnt_next;
            end
            if (w_own_rlast && (w_cnt_next != w_expect)) begin
              r_err <= 1'b1;
            end
            if (!w_own_rlast && (w_cnt_next > w_expect)) begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign inst_ren    = r_owner;
  assign cache_ena   = r_cached;
  assign inst_araddr = r_addr;
  assign data_araddr = r_addr;
  assign beat_idx    = r_beat_idx;
  assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_read_arb.sv
//------------------------------------------------------------------------------
// Module  : tb_axi_read_arb
// Purpose : Directed self-checking bench for axi_read_arb.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_read_arb;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_cached, data_req, data_cached;
  logic [31:0] inst_addr, data_addr;
  logic        inst_done, data_done;
  logic [3:0]  beat_idx;
  logic        inst_ren, cache_ena;
  logic        inst_arvalid, data_arvalid;
  logic [31:0] inst_araddr, data_araddr;
  logic        inst_arready, data_arready;
  logic        inst_rvalid, inst_rlast, data_rvalid, data_rlast;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  axi_read_arb #(.BEATS(16)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cached(inst_cached),
    .data_req(data_req), .data_addr(data_addr), .data_cached(data_cached),
    .inst_done(inst_done), .data_done(data_done), .beat_idx(beat_idx),
    .inst_ren(inst_ren), .cache_ena(cache_ena),
    .inst_arvalid(inst_arvalid), .data_arvalid(data_arvalid),
    .inst_araddr(inst_araddr), .data_araddr(data_araddr),
    .inst_arready(inst_arready), .data_arready(data_arready),
    .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast),
    .data_rvalid(data_rvalid), .data_rlast(data_rlast),
    .err(err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = 0; inst_cached = 0;
    data_req = 0; data_addr = 0; data_cached = 0;
    inst_arready = 0; data_arready = 0;
    inst_rvalid = 0; inst_rlast = 0; data_rvalid = 0; data_rlast = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut.r_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, ST_IDLE);
    else n_pass++;
    n_checks++;
    if ({inst_arvalid, data_arvalid, inst_done, data_done} !== 4'b0000)
      $display("FAIL reset_valids got=%b exp=0000", {inst_arvalid, data_arvalid, inst_done, data_done});
    else n_pass++;
    n_checks++;
    if ({beat_idx, inst_ren, cache_ena, err} !== 7'b0)
      $display("FAIL reset_regs got beat=%0d ren=%b ena=%b err=%b exp all 0", beat_idx, inst_ren, cache_ena, err);
    else n_pass++;
  endtask

  task automatic test_inst_burst();
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_cached = 1;
    tick();
    inst_req = 0; inst_arready = 1;
    #1;
    n_checks++;
    if ({inst_arvalid, data_arvalid} !== 2'b10 || inst_araddr !== 32'hBFC0_0000)
      $display("FAIL burst_ar got arv=%b%b addr=%h exp arv=10 addr=bfc00000", inst_arvalid, data_arvalid, inst_araddr);
    else n_pass++;
    n_checks++;
    if ({inst_ren, cache_ena} !== 2'b11) $display("FAIL burst_owner got=%b%b exp=11", inst_ren, cache_ena);
    else n_pass++;
    tick();
    inst_arready = 0;
    for (int k = 0; k < 16; k++) begin
      inst_rvalid = 1; inst_rlast = (k == 15);
      #1;
      n_checks++;
      if (beat_idx !== 4'(k) || inst_done !== (k == 15))
        $display("FAIL burst_beat%0d got idx=%0d done=%b exp idx=%0d done=%b", k, beat_idx, inst_done, k, (k == 15));
      else n_pass++;
      tick();
    end
    inst_rvalid = 0; inst_rlast = 0;
    #1;
    n_checks++;
    if (dut.r_state !== ST_IDLE || err !== 1'b0 || inst_done !== 1'b0)
      $display("FAIL burst_end got st=%0d err=%b done=%b exp st=0 err=0 done=0", dut.r_state, err, inst_done);
    else n_pass++;
  endtask

  task automatic test_tie();
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_1000; inst_cached = 0;
    data_req = 1; data_addr = 32'h0000_2000; data_cached = 0;
    tick();
    data_arready = 1;
    #1;
    n_checks++;
    if ({inst_arvalid, data_arvalid, inst_ren} !== 3'b010 || data_araddr !== 32'h0000_2000)
      $display("FAIL tie_first got iarv=%b darv=%b ren=%b addr=%h exp 0 1 0 00002000", inst_arvalid, data_arvalid, inst_ren, data_araddr);
    else n_pass++;
    tick();
    data_arready = 0; data_req = 0; data_rvalid = 1; data_rlast = 1;
    #1;
    n_checks++;
    if ({data_done, inst_done} !== 2'b10) $display("FAIL tie_data_done got=%b%b exp=10", data_done, inst_done);
    else n_pass++;
    tick();
    data_rvalid = 0; data_rlast = 0;
    #1;
    n_checks++;
    if (dut.r_state !== ST_IDLE || inst_arvalid !== 1'b0)
      $display("FAIL tie_bubble got st=%0d iarv=%b exp st=0 iarv=0", dut.r_state, inst_arvalid);
    else n_pass++;
    tick();
    inst_req = 0; inst_arready = 1;
    #1;
    n_checks++;
    if ({inst_arvalid, data_arvalid, inst_ren} !== 3'b101 || inst_araddr !== 32'h0000_1000)
      $display("FAIL tie_second got iarv=%b darv=%b ren=%b addr=%h exp 1 0 1 00001000", inst_arvalid, data_arvalid, inst_ren, inst_araddr);
    else n_pass++;
    tick();
    inst_arready = 0; inst_rvalid = 1; inst_rlast = 1;
    #1;
    n_checks++;
    if (inst_done !== 1'b1) $display("FAIL tie_inst_done got=%b exp=1", inst_done);
    else n_pass++;
    tick();
    inst_rvalid = 0; inst_rlast = 0;
  endtask

  task automatic test_uncached_data();
    data_req = 1; data_addr = 32'h1FAF_0000; data_cached = 0;
    tick();
    data_req = 0; data_arready = 1;
    #1;
    n_checks++;
    if (data_arvalid !== 1'b1 || data_araddr !== 32'h1FAF_0000 || cache_ena !== 1'b0 || inst_ren !== 1'b0)
      $display("FAIL unc_ar got arv=%b addr=%h ena=%b ren=%b exp 1 1faf0000 0 0", data_arvalid, data_araddr, cache_ena, inst_ren);
    else n_pass++;
    tick();
    data_arready = 0; data_rvalid = 1; data_rlast = 1;
    #1;
    n_checks++;
    if (data_done !== 1'b1 || cache_ena !== 1'b0) $display("FAIL unc_done got done=%b ena=%b exp 1 0", data_done, cache_ena);
    else n_pass++;
    tick();
    data_rvalid = 0; data_rlast = 0;
    #1;
    n_checks++;
    if (err !== 1'b0 || dut.r_state !== ST_IDLE) $display("FAIL unc_err got err=%b st=%0d exp 0 0", err, dut.r_state);
    else n_pass++;
  endtask

  task automatic test_short_burst();
    inst_req = 1; inst_addr = 32'h8000_0040; inst_cached = 1;
    tick();
    inst_req = 0; inst_arready = 1;
    tick();
    inst_arready = 0;
    for (int k = 0; k < 8; k++) begin
      inst_rvalid = 1; inst_rlast = (k == 7);
      #1;
      if (k == 7) begin
        n_checks++;
        if (inst_done !== 1'b1) $display("FAIL short_done got=%b exp=1", inst_done);
        else n_pass++;
      end
      tick();
    end
    inst_rvalid = 0; inst_rlast = 0;
    #1;
    n_checks++;
    if (dut.r_state !== ST_IDLE || err !== 1'b1) $display("FAIL short_err got st=%0d err=%b exp 0 1", dut.r_state, err);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (err !== 1'b1) $display("FAIL short_sticky got=%b exp=1", err);
    else n_pass++;
    do_reset();
    n_checks++;
    if (err !== 1'b0) $display("FAIL short_clear got=%b exp=0", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    inst_req = 1; inst_addr = 32'h8000_0100; inst_cached = 1;
    tick();
    inst_req = 0; inst_arready = 1;
    tick();
    inst_arready = 0;
    for (int k = 0; k < 5; k++) begin
      inst_rvalid = 1; inst_rlast = 0;
      tick();
    end
    rst = 1; inst_rvalid = 1; inst_rlast = 1;
    #1;
    n_checks++;
    if (inst_done !== 1'b0) $display("FAIL midrst_nodone got=%b exp=0", inst_done);
    else n_pass++;
    tick();
    rst = 0; inst_rvalid = 0; inst_rlast = 0;
    #1;
    n_checks++;
    if (dut.r_state !== ST_IDLE || {inst_arvalid, data_arvalid, inst_done, data_done} !== 4'b0 || beat_idx !== 4'd0)
      $display("FAIL midrst_state got st=%0d v=%b idx=%0d exp st=0 v=0000 idx=0", dut.r_state,
               {inst_arvalid, data_arvalid, inst_done, data_done}, beat_idx);
    else n_pass++;
  endtask

  task automatic test_stall_spurious();
    inst_req = 1; inst_addr = 32'h0040_0000; inst_cached = 0;
    tick();
    inst_req = 0; data_rvalid = 1; data_rlast = 1; data_arready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (inst_arvalid !== 1'b1 || data_arvalid !== 1'b0 || data_done !== 1'b0 || inst_araddr !== 32'h0040_0000)
        $display("FAIL stall%0d got iarv=%b darv=%b ddone=%b addr=%h exp 1 0 0 00400000", k, inst_arvalid, data_arvalid, data_done, inst_araddr);
      else n_pass++;
      tick();
    end
    inst_arready = 1;
    tick();
    inst_arready = 0; inst_rvalid = 1; inst_rlast = 1;
    #1;
    n_checks++;
    if ({inst_done, data_done} !== 2'b10) $display("FAIL stall_done got=%b%b exp=10", inst_done, data_done);
    else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (dut.r_state !== ST_IDLE || err !== 1'b0) $display("FAIL stall_end got st=%0d err=%b exp 0 0", dut.r_state, err);
    else n_pass++;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_inst_burst();
    test_tie();
    test_uncached_data();
    test_short_burst();
    test_reset_mid();
    test_stall_spurious();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
